// File: rtl/dice_pkg.sv
// Shared definitions for the craps-style dice game controller:
// FSM state encoding, default dice-sum width and the significant dice totals.
package dice_pkg;

    localparam int SUM_W_DEF = 4;

    localparam int unsigned SUM_SEVEN   = 7;
    localparam int unsigned SUM_ELEVEN  = 11;
    localparam int unsigned SUM_SNAKE   = 2;
    localparam int unsigned SUM_THREE   = 3;
    localparam int unsigned SUM_BOXCARS = 12;
    localparam int unsigned SUM_MIN     = 2;
    localparam int unsigned SUM_MAX     = 12;

    typedef enum logic [2:0] {
        IDLE,
        ROLL1,
        PT_WAIT,
        PT_ROLL,
        WIN,
        LOSE
    } dice_state_e;

endpackage

// File: rtl/dice_sat_counter.sv
// Saturating up-counter used for the roll, win and loss tallies.
// Only the asynchronous reset clears it; it sticks at all-ones.
module dice_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dice_game_ctrl.sv
// Craps-style dice game controller: requests rolls, applies first-roll and
// point rules to each Sum, holds Win/Lose until a game restart, keeps tallies.
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Rb,
    input  logic             Reset,
    input  logic [SUM_W-1:0] Sum,
    output logic             Roll,
    output logic             Win,
    output logic             Lose,
    output logic [SUM_W-1:0] Point,
    output logic             SumErr,
    output logic [CNT_W-1:0] RollCnt,
    output logic [CNT_W-1:0] WinCnt,
    output logic [CNT_W-1:0] LoseCnt
);

    localparam logic [SUM_W-1:0] S_SEVEN   = SUM_W'(SUM_SEVEN);
    localparam logic [SUM_W-1:0] S_ELEVEN  = SUM_W'(SUM_ELEVEN);
    localparam logic [SUM_W-1:0] S_SNAKE   = SUM_W'(SUM_SNAKE);
    localparam logic [SUM_W-1:0] S_THREE   = SUM_W'(SUM_THREE);
    localparam logic [SUM_W-1:0] S_BOXCARS = SUM_W'(SUM_BOXCARS);
    localparam logic [SUM_W-1:0] S_MIN     = SUM_W'(SUM_MIN);
    localparam logic [SUM_W-1:0] S_MAX     = SUM_W'(SUM_MAX);

    dice_state_e      state_q, state_d;
    logic [SUM_W-1:0] point_q, point_d;
    logic             sum_err_q, sum_err_d;
    logic             roll_q, win_q, lose_q;
    logic             sum_valid;
    logic             roll_inc;
    logic             win_inc;
    logic             lose_inc;

    assign sum_valid = (Sum >= S_MIN) && (Sum <= S_MAX);

    // Game restart outranks the roll button, so a roll in flight is dropped uncounted.
    always_comb begin
        state_d   = state_q;
        point_d   = point_q;
        sum_err_d = 1'b0;
        roll_inc  = 1'b0;
        if (Reset) begin
            state_d = IDLE;
            point_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Rb) state_d = ROLL1;
                end
                ROLL1: begin
                    if (!Rb) begin
                        if (!sum_valid) begin
                            sum_err_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            roll_inc = 1'b1;
                            if ((Sum == S_SEVEN) || (Sum == S_ELEVEN)) begin
                                state_d = WIN;
                            end else if ((Sum == S_SNAKE) || (Sum == S_THREE) ||
                                         (Sum == S_BOXCARS)) begin
                                state_d = LOSE;
                            end else begin
                                point_d = Sum;
                                state_d = PT_WAIT;
                            end
                        end
                    end
                end
                PT_WAIT: begin
                    if (Rb) state_d = PT_ROLL;
                end
                PT_ROLL: begin
                    if (!Rb) begin
                        if (!sum_valid) begin
                            sum_err_d = 1'b1;
                            state_d   = PT_WAIT;
                        end else begin
                            roll_inc = 1'b1;
                            if (Sum == point_q) begin
                                state_d = WIN;
                            end else if (Sum == S_SEVEN) begin
                                state_d = LOSE;
                            end else begin
                                state_d = PT_WAIT;
                            end
                        end
                    end
                end
                WIN, LOSE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign win_inc  = (state_d == WIN)  && (state_q != WIN);
    assign lose_inc = (state_d == LOSE) && (state_q != LOSE);

    // Outputs are registered from the next state so they match the decoded state exactly.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            point_q   <= '0;
            sum_err_q <= 1'b0;
            roll_q    <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            point_q   <= point_d;
            sum_err_q <= sum_err_d;
            roll_q    <= (state_d == ROLL1) || (state_d == PT_ROLL);
            win_q     <= (state_d == WIN);
            lose_q    <= (state_d == LOSE);
        end
    end

    dice_sat_counter #(.CNT_W(CNT_W)) u_roll_cnt (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .inc     (roll_inc),
        .count   (RollCnt)
    );

    dice_sat_counter #(.CNT_W(CNT_W)) u_win_cnt (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .inc     (win_inc),
        .count   (WinCnt)
    );

    dice_sat_counter #(.CNT_W(CNT_W)) u_lose_cnt (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .inc     (lose_inc),
        .count   (LoseCnt)
    );

    assign Roll   = roll_q;
    assign Win    = win_q;
    assign Lose   = lose_q;
    assign Point  = point_q;
    assign SumErr = sum_err_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: a table of game vectors plus
// hand-written sequences for async reset, counter saturation and restart priority.
module tb_dice_game_ctrl;

    logic       CLK;
    logic       Reset_n;
    logic       Rb;
    logic       Reset;
    logic [3:0] Sum;
    logic       Roll;
    logic       Win;
    logic       Lose;
    logic [3:0] Point;
    logic       SumErr;
    logic [7:0] RollCnt;
    logic [7:0] WinCnt;
    logic [7:0] LoseCnt;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic       roll;
        logic       win;
        logic       lose;
        logic [3:0] point;
        logic       err;
        logic [7:0] rc;
        logic [7:0] wc;
        logic [7:0] lc;
        string      name;
    } exp_t;

    typedef struct {
        logic       rb;
        logic       rst;
        logic [3:0] sum;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    exp_t scoreboard[$];

    dice_game_ctrl #(.SUM_W(4), .CNT_W(8)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .Rb      (Rb),
        .Reset   (Reset),
        .Sum     (Sum),
        .Roll    (Roll),
        .Win     (Win),
        .Lose    (Lose),
        .Point   (Point),
        .SumErr  (SumErr),
        .RollCnt (RollCnt),
        .WinCnt  (WinCnt),
        .LoseCnt (LoseCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t mkExp(input logic roll, input logic win, input logic lose,
                                   input logic [3:0] point, input logic err,
                                   input int rc, input int wc, input int lc,
                                   input string name);
        exp_t e;
        e.roll  = roll;
        e.win   = win;
        e.lose  = lose;
        e.point = point;
        e.err   = err;
        e.rc    = rc[7:0];
        e.wc    = wc[7:0];
        e.lc    = lc[7:0];
        e.name  = name;
        return e;
    endfunction

    function automatic void addVec(input logic rb, input logic rst, input logic [3:0] sum,
                                   input logic roll, input logic win, input logic lose,
                                   input logic [3:0] point, input logic err,
                                   input int rc, input int wc, input int lc,
                                   input string name);
        vec_t v;
        v.rb  = rb;
        v.rst = rst;
        v.sum = sum;
        v.e   = mkExp(roll, win, lose, point, err, rc, wc, lc, name);
        vecs.push_back(v);
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic checkOutput();
        exp_t e;
        logic [31:0] act;
        logic [31:0] req;
        if (scoreboard.size() == 0) begin
            failCount++;
            checkCount++;
            $display("[TB] FAIL scoreboard_empty: actual no entry, required one entry");
            return;
        end
        e   = scoreboard.pop_front();
        act = {Roll, Win, Lose, Point, SumErr, RollCnt, WinCnt, LoseCnt};
        req = {e.roll, e.win, e.lose, e.point, e.err, e.rc, e.wc, e.lc};
        checkCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: actual roll=%b win=%b lose=%b point=%0d err=%b rc=%0d wc=%0d lc=%0d, required roll=%b win=%b lose=%b point=%0d err=%b rc=%0d wc=%0d lc=%0d",
                     e.name, Roll, Win, Lose, Point, SumErr, RollCnt, WinCnt, LoseCnt,
                     e.roll, e.win, e.lose, e.point, e.err, e.rc, e.wc, e.lc);
        end
    endtask

    task automatic applyStimulus(input logic rb, input logic rst, input logic [3:0] sum,
                                 input exp_t e);
        Rb    = rb;
        Reset = rst;
        Sum   = sum;
        scoreboard.push_back(e);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        // rb rst sum | roll win lose point err rc wc lc
        addVec(1, 0,  7, 1, 0, 0, 0, 0,  0, 0, 0, "r7_press");
        addVec(1, 0,  7, 1, 0, 0, 0, 0,  0, 0, 0, "r7_hold");
        addVec(0, 0,  7, 0, 1, 0, 0, 0,  1, 1, 0, "r7_win");
        addVec(1, 0,  3, 0, 1, 0, 0, 0,  1, 1, 0, "win_ignores_rb");
        addVec(0, 1,  0, 0, 0, 0, 0, 0,  1, 1, 0, "restart_1");
        addVec(1, 0, 11, 1, 0, 0, 0, 0,  1, 1, 0, "r11_press");
        addVec(0, 0, 11, 0, 1, 0, 0, 0,  2, 2, 0, "r11_win");
        addVec(0, 1,  0, 0, 0, 0, 0, 0,  2, 2, 0, "restart_2");
        addVec(1, 0,  2, 1, 0, 0, 0, 0,  2, 2, 0, "r2_press");
        addVec(0, 0,  2, 0, 0, 1, 0, 0,  3, 2, 1, "r2_lose");
        addVec(0, 1,  0, 0, 0, 0, 0, 0,  3, 2, 1, "restart_3");
        addVec(1, 0,  4, 1, 0, 0, 0, 0,  3, 2, 1, "r4_press");
        addVec(0, 0,  4, 0, 0, 0, 4, 0,  4, 2, 1, "r4_point");
        addVec(0, 0,  0, 0, 0, 0, 4, 0,  4, 2, 1, "pt_wait_idle");
        addVec(1, 0,  7, 1, 0, 0, 4, 0,  4, 2, 1, "pt4_press7");
        addVec(0, 0,  7, 0, 0, 1, 4, 0,  5, 2, 2, "pt4_lose7");
        addVec(0, 1,  0, 0, 0, 0, 0, 0,  5, 2, 2, "restart_point_clear");
        addVec(1, 0,  5, 1, 0, 0, 0, 0,  5, 2, 2, "r5_press");
        addVec(0, 0,  5, 0, 0, 0, 5, 0,  6, 2, 2, "r5_point");
        addVec(1, 0,  6, 1, 0, 0, 5, 0,  6, 2, 2, "pt5_press6");
        addVec(0, 0,  6, 0, 0, 0, 5, 0,  7, 2, 2, "pt5_miss6");
        addVec(1, 0,  7, 1, 0, 0, 5, 0,  7, 2, 2, "pt5_press7");
        addVec(0, 0,  7, 0, 0, 1, 5, 0,  8, 2, 3, "pt5_lose7");
        addVec(0, 1,  0, 0, 0, 0, 0, 0,  8, 2, 3, "restart_4");
        addVec(1, 0,  6, 1, 0, 0, 0, 0,  8, 2, 3, "r6_press");
        addVec(0, 0,  6, 0, 0, 0, 6, 0,  9, 2, 3, "r6_point");
        addVec(1, 0,  8, 1, 0, 0, 6, 0,  9, 2, 3, "pt6_press8");
        addVec(0, 0,  8, 0, 0, 0, 6, 0, 10, 2, 3, "pt6_miss8");
        addVec(1, 0,  9, 1, 0, 0, 6, 0, 10, 2, 3, "pt6_press9");
        addVec(0, 0,  9, 0, 0, 0, 6, 0, 11, 2, 3, "pt6_miss9");
        addVec(1, 0,  6, 1, 0, 0, 6, 0, 11, 2, 3, "pt6_press6");
        addVec(0, 0,  6, 0, 1, 0, 6, 0, 12, 3, 3, "pt6_win");
        addVec(0, 1,  0, 0, 0, 0, 0, 0, 12, 3, 3, "restart_5");
        addVec(1, 0,  0, 1, 0, 0, 0, 0, 12, 3, 3, "r0_press");
        addVec(0, 0,  0, 0, 0, 0, 0, 1, 12, 3, 3, "r0_sumerr");
        addVec(0, 0,  0, 0, 0, 0, 0, 0, 12, 3, 3, "sumerr_pulse_end");
        addVec(1, 0, 13, 1, 0, 0, 0, 0, 12, 3, 3, "r13_press");
        addVec(0, 0, 13, 0, 0, 0, 0, 1, 12, 3, 3, "r13_sumerr");
        addVec(1, 0,  4, 1, 0, 0, 0, 0, 12, 3, 3, "r4b_press");
        addVec(0, 0,  4, 0, 0, 0, 4, 0, 13, 3, 3, "r4b_point");
        addVec(1, 0, 15, 1, 0, 0, 4, 0, 13, 3, 3, "pt4_press15");
        addVec(0, 0, 15, 0, 0, 0, 4, 1, 13, 3, 3, "pt4_sumerr15");
        addVec(0, 0,  0, 0, 0, 0, 4, 0, 13, 3, 3, "pt_sumerr_end");
        addVec(1, 0, 12, 1, 0, 0, 4, 0, 13, 3, 3, "pt4_press12");
        addVec(1, 1, 12, 0, 0, 0, 0, 0, 13, 3, 3, "pt_roll_restart");
        addVec(0, 0,  0, 0, 0, 0, 0, 0, 13, 3, 3, "idle_after_restart");
        addVec(1, 0,  7, 1, 0, 0, 0, 0, 13, 3, 3, "r7b_press");
        addVec(0, 1,  7, 0, 0, 0, 0, 0, 13, 3, 3, "roll1_restart_drop");
        addVec(0, 0,  7, 0, 0, 0, 0, 0, 13, 3, 3, "idle_hold");
        addVec(1, 0, 12, 1, 0, 0, 0, 0, 13, 3, 3, "r12_press");
        addVec(0, 0, 12, 0, 0, 1, 0, 0, 14, 3, 4, "r12_lose");
        addVec(0, 1,  0, 0, 0, 0, 0, 0, 14, 3, 4, "restart_6");
        addVec(1, 0,  3, 1, 0, 0, 0, 0, 14, 3, 4, "r3_press");
        addVec(0, 0,  3, 0, 0, 1, 0, 0, 15, 3, 5, "r3_lose");
        addVec(0, 1,  0, 0, 0, 0, 0, 0, 15, 3, 5, "restart_7");

        Reset_n = 1'b0;
        Rb      = 1'b0;
        Reset   = 1'b0;
        Sum     = '0;
        repeat (2) @(posedge CLK);
        #1;
        scoreboard.push_back(mkExp(0, 0, 0, 0, 0, 0, 0, 0, "reset_state"));
        checkOutput();
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rb, vecs[i].rst, vecs[i].sum, vecs[i].e);
        end

        // Asynchronous reset landing in the middle of a point roll.
        applyStimulus(1, 0, 8, mkExp(1, 0, 0, 0, 0, 15, 3, 5, "ar_press8"));
        applyStimulus(0, 0, 8, mkExp(0, 0, 0, 8, 0, 16, 3, 5, "ar_point8"));
        applyStimulus(1, 0, 5, mkExp(1, 0, 0, 8, 0, 16, 3, 5, "ar_pt_roll"));
        #3;
        Reset_n = 1'b0;
        #1;
        scoreboard.push_back(mkExp(0, 0, 0, 0, 0, 0, 0, 0, "async_reset_immediate"));
        checkOutput();
        @(posedge CLK);
        #1;
        scoreboard.push_back(mkExp(0, 0, 0, 0, 0, 0, 0, 0, "async_reset_held"));
        checkOutput();
        Reset_n = 1'b1;
        applyStimulus(1, 0, 0, mkExp(1, 0, 0, 0, 0, 0, 0, 0, "post_reset_roll"));
        applyStimulus(0, 0, 0, mkExp(0, 0, 0, 0, 1, 0, 0, 0, "post_reset_sumerr"));
        applyStimulus(0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, "post_reset_idle"));

        // Drive the win and roll tallies past saturation.
        for (int g = 1; g <= 256; g++) begin
            applyStimulus(1, 0, 7, mkExp(1, 0, 0, 0, 0, sat(g - 1), sat(g - 1), 0, "sat_press"));
            applyStimulus(0, 0, 7, mkExp(0, 1, 0, 0, 0, sat(g), sat(g), 0, "sat_win"));
            if (g < 256) begin
                applyStimulus(0, 1, 0, mkExp(0, 0, 0, 0, 0, sat(g), sat(g), 0, "sat_restart"));
            end
        end

        applyStimulus(1, 1, 7, mkExp(0, 0, 0, 0, 0, 255, 255, 0, "win_restart_with_rb"));
        applyStimulus(0, 0, 7, mkExp(0, 0, 0, 0, 0, 255, 255, 0, "no_roll_until_rb"));
        applyStimulus(1, 0, 7, mkExp(1, 0, 0, 0, 0, 255, 255, 0, "next_rb_rolls"));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
